// File: rtl/fixed_point_integrate_dump.sv
// rtl/fixed_point_integrate_dump.sv - integrate-and-dump of a saturating Q-format sample stream
// Optional feature macro: FIXED_POINT_INTDUMP_AVG_EN (rounded window mean instead of saturated sum)
module fixed_point_integrate_dump #(
   parameter int  WIDTH    = 8,
   parameter int  FBITS    = 4,
   parameter int  DUMP_LEN = 4,
   localparam int CW       = $clog2(DUMP_LEN + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_overflow,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_val,
   output logic             o_overflow,
   output logic             o_drop,
   output logic [CW-1:0]    o_count
);

   localparam int LW = $clog2(DUMP_LEN);
   localparam int AW = WIDTH + LW;
   localparam logic signed [AW:0] MAX_V = (AW+1)'(2**(WIDTH-1) - 1);
   localparam logic signed [AW:0] MIN_V = (AW+1)'(-(2**(WIDTH-1)));

   if (FBITS < 0 || FBITS > WIDTH - 1) begin : g_bad_fbits
      $error("FBITS must lie in 0..WIDTH-1");
   end
   if (DUMP_LEN < 1) begin : g_bad_len
      $error("DUMP_LEN must be at least 1");
   end

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   state_t                  state;
   logic signed [AW-1:0]    acc;
   logic signed [AW-1:0]    sum;
   logic [CW-1:0]           count;
   logic                    sticky;
   logic signed [WIDTH-1:0] val_s;
   logic                    accept;
   logic                    complete;
   logic signed [AW:0]      pre;
   logic                    sat_hi;
   logic                    sat_lo;
   logic [WIDTH-1:0]        result;
   logic                    result_ovf;

   // Running sum including the current sample, and the saturated window result
   always_comb begin
      val_s    = i_val;
      accept   = i_valid && !i_clear;
      complete = accept && (count == CW'(DUMP_LEN - 1));
      sum      = acc + AW'(val_s);
`ifdef FIXED_POINT_INTDUMP_AVG_EN
      pre      = ((AW+1)'(sum) + (AW+1)'(DUMP_LEN / 2)) >>> LW;
`else
      pre      = (AW+1)'(sum);
`endif
      sat_hi   = pre > MAX_V;
      sat_lo   = pre < MIN_V;
      if (sat_hi)
         result = {1'b0, {(WIDTH-1){1'b1}}};
      else if (sat_lo)
         result = {1'b1, {(WIDTH-1){1'b0}}};
      else
         result = pre[WIDTH-1:0];
`ifdef FIXED_POINT_INTDUMP_AVG_EN
      result_ovf = sticky | i_overflow;
`else
      result_ovf = sticky | i_overflow | sat_hi | sat_lo;
`endif
   end

   // Window accumulation plus the output-register state machine
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc        <= '0;
         count      <= '0;
         sticky     <= 1'b0;
         o_val      <= '0;
         o_overflow <= 1'b0;
         o_drop     <= 1'b0;
         state      <= ST_EMPTY;
      end else begin
         o_drop <= 1'b0;

         if (i_clear || complete) begin
            acc    <= '0;
            count  <= '0;
            sticky <= 1'b0;
         end else if (accept) begin
            acc    <= sum;
            count  <= count + CW'(1);
            sticky <= sticky | i_overflow;
         end

         case (state)
            ST_EMPTY: begin
               if (complete) begin
                  o_val      <= result;
                  o_overflow <= result_ovf;
                  state      <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (complete) begin
                  if (i_ready) begin
                     o_val      <= result;
                     o_overflow <= result_ovf;
                  end else begin
                     o_drop <= 1'b1;
                  end
               end else if (i_ready) begin
                  state <= ST_EMPTY;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   assign o_valid = (state == ST_FULL);
   assign o_count = count;

endmodule

// File: tb/tb_fixed_point_integrate_dump.sv
// tb/tb_fixed_point_integrate_dump.sv - directed self-checking bench for fixed_point_integrate_dump
module tb_fixed_point_integrate_dump;

   localparam int WIDTH    = 8;
   localparam int DUMP_LEN = 4;
   localparam int CW       = $clog2(DUMP_LEN + 1);

`ifdef FIXED_POINT_INTDUMP_AVG_EN
   localparam logic [7:0] E1_V = 8'h10, E2_V = 8'h70, E3_V = 8'h80;
   localparam logic [7:0] E4_V = 8'h10, E5_V = 8'h08, E6_V = 8'h28;
   localparam logic       E2_O = 1'b0, E3_O = 1'b0, E6_O = 1'b0;
`else
   localparam logic [7:0] E1_V = 8'h40, E2_V = 8'h7F, E3_V = 8'h80;
   localparam logic [7:0] E4_V = 8'h40, E5_V = 8'h20, E6_V = 8'h7F;
   localparam logic       E2_O = 1'b1, E3_O = 1'b1, E6_O = 1'b1;
`endif

   logic             i_clk      = 1'b0;
   logic             i_rst_n    = 1'b0;
   logic             i_clear    = 1'b0;
   logic             i_valid    = 1'b0;
   logic [WIDTH-1:0] i_val      = '0;
   logic             i_overflow = 1'b0;
   logic             i_ready    = 1'b1;
   logic             o_valid;
   logic [WIDTH-1:0] o_val;
   logic             o_overflow;
   logic             o_drop;
   logic [CW-1:0]    o_count;

   int n_total = 0;
   int n_pass  = 0;
   int n_drop  = 0;

   always #5 i_clk = ~i_clk;

   fixed_point_integrate_dump #(
      .WIDTH    (WIDTH),
      .FBITS    (4),
      .DUMP_LEN (DUMP_LEN)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clear    (i_clear),
      .i_valid    (i_valid),
      .i_val      (i_val),
      .i_overflow (i_overflow),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_val      (o_val),
      .o_overflow (o_overflow),
      .o_drop     (o_drop),
      .o_count    (o_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] v, input logic ov);
      i_valid    = 1'b1;
      i_val      = v;
      i_overflow = ov;
      tick();
      i_valid    = 1'b0;
      i_overflow = 1'b0;
   endtask

   task automatic push4(input logic [7:0] v);
      repeat (4) push(v, 1'b0);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] v, input logic ov);
      chk({tag, ".valid"}, 32'(o_valid), 32'd1);
      chk({tag, ".val"}, 32'(o_val), 32'(v));
      chk({tag, ".ovf"}, 32'(o_overflow), 32'(ov));
   endtask

   initial begin
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst.valid", 32'(o_valid), 32'd0);
      chk("rst.val", 32'(o_val), 32'd0);
      chk("rst.ovf", 32'(o_overflow), 32'd0);
      chk("rst.drop", 32'(o_drop), 32'd0);
      chk("rst.count", 32'(o_count), 32'd0);
      i_rst_n = 1'b1;
      tick();

      // four 1.0 samples
      repeat (3) push(8'h10, 1'b0);
      chk("w1.count3", 32'(o_count), 32'd3);
      chk("w1.valid_early", 32'(o_valid), 32'd0);
      push(8'h10, 1'b0);
      chk_out("w1", E1_V, 1'b0);
      chk("w1.count0", 32'(o_count), 32'd0);
      tick();
      chk("w1.drain", 32'(o_valid), 32'd0);

      // positive and negative saturation
      push4(8'h70);
      chk_out("pos_sat", E2_V, E2_O);
      tick();
      push4(8'h80);
      chk_out("neg_sat", E3_V, E3_O);
      tick();

      // upstream overflow is sticky across the window
      push(8'h10, 1'b0);
      push(8'h10, 1'b1);
      push(8'h10, 1'b0);
      push(8'h10, 1'b0);
      chk_out("sticky", E4_V, 1'b1);
      tick();

      // backpressure: second window dropped, first held
      i_ready = 1'b0;
      n_drop  = 0;
      for (int i = 0; i < 8; i++) begin
         push(8'h08, 1'b0);
         if (i < 7) n_drop += int'(o_drop);
         if (i == 3) chk_out("bp.first", E5_V, 1'b0);
      end
      chk("bp.early_drops", 32'(n_drop), 32'd0);
      chk("bp.drop", 32'(o_drop), 32'd1);
      chk("bp.held", 32'(o_val), 32'(E5_V));
      tick();
      chk("bp.drop_pulse", 32'(o_drop), 32'd0);
      chk("bp.still_valid", 32'(o_valid), 32'd1);
      i_ready = 1'b1;
      tick();
      chk("bp.release", 32'(o_valid), 32'd0);

      // asynchronous reset mid-window
      push(8'h30, 1'b0);
      push(8'h30, 1'b0);
      chk("rmid.count2", 32'(o_count), 32'd2);
      #3 i_rst_n = 1'b0;
      #1;
      chk("rmid.count", 32'(o_count), 32'd0);
      chk("rmid.val", 32'(o_val), 32'd0);
      chk("rmid.valid", 32'(o_valid), 32'd0);
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      push4(8'h08);
      chk_out("rmid", E5_V, 1'b0);
      tick();

      // clear mid-window, clear beats a simultaneous sample
      push(8'h30, 1'b0);
      push(8'h30, 1'b0);
      i_clear = 1'b1;
      push(8'h30, 1'b0);
      i_clear = 1'b0;
      chk("clr.count", 32'(o_count), 32'd0);
      chk("clr.valid", 32'(o_valid), 32'd0);
      push4(8'h08);
      chk_out("clr", E5_V, 1'b0);
      tick();

      // accept and completion in the same cycle: reload, no drop
      i_ready = 1'b0;
      push4(8'h10);
      chk_out("rc.first", E1_V, 1'b0);
      repeat (3) push(8'h08, 1'b0);
      i_ready = 1'b1;
      push(8'h08, 1'b0);
      chk_out("rc.second", E5_V, 1'b0);
      chk("rc.drop", 32'(o_drop), 32'd0);
      tick();
      chk("rc.drain", 32'(o_valid), 32'd0);

      // mixed samples
      push(8'h10, 1'b0);
      push(8'h20, 1'b0);
      push(8'h30, 1'b0);
      push(8'h41, 1'b0);
      chk_out("mixed", E6_V, E6_O);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
